commit_ctrl: RTL and testbench

COMMIT_CTRL -- requirements
Module: commit_ctrl

---
 rtl/npc_commit_pkg.sv | 33 +++
 rtl/commit_fifo.sv | 72 +++++++
 rtl/commit_ctrl.sv | 154 +++++++++++++++
 tb/tb_commit_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_commit_pkg.sv
// npc_commit_pkg
// Shared types and constants for the commit controller and its commit FIFO.
//   state_t      : controller FSM states (IDLE, RUN, DRAIN, HALT)
//   halt_code_t  : simulation end cause reported on halt_code
//   commit_rec_t : one retired-instruction record {pc, inst}
//   FIFO_DEPTH   : number of commit records buffered towards difftest
//   FIFO_CNT_W   : width of the FIFO occupancy count (must hold 0..FIFO_DEPTH)
package npc_commit_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    HC_NONE    = 2'b00,
    HC_GOOD    = 2'b01,
    HC_BAD     = 2'b10,
    HC_TIMEOUT = 2'b11
  } halt_code_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// commit_fifo
// Small valid/ready buffer holding commit records between the core and the
// difftest consumer. Push and pop may happen in the same cycle; a push into a
// full buffer or a pop from an empty one is ignored.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (empties the buffer)
//   push        : write push_data when not full
//   push_data   : record to store
//   pop         : drop the head record when not empty
//   full, empty : occupancy flags
//   level       : current number of stored records
//   head        : oldest record, forced to zero while empty
module commit_fifo
  import npc_commit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  commit_rec_t           push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] level,
  output commit_rec_t           head
);

  commit_rec_t           mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_CNT_W-1:0] count;
  logic                  push_fire;
  logic                  pop_fire;

  assign full      = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign level     = count;
  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;

  // Gating the head keeps the difftest record at zero whenever nothing valid
  // is buffered, including straight after reset.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl
// Collects retiring instructions from the core, forwards them to difftest
// through a 2-entry commit FIFO, keeps retired-instruction and active-cycle
// counters, and ends the simulation on ebreak (GOOD/BAD trap from a0).
// Optional build macro COMMIT_CTRL_WDOG_EN adds a no-commit watchdog that
// halts with TIMEOUT after WDOG_LIMIT consecutive RUN cycles without a commit.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   inst_valid, inst, pc  : retiring instruction from the core
//   is_break, a0          : ebreak marker and GPR x10 for the halt cause
//   stall                 : core must hold its commit signals
//   dt_valid, dt_ready    : difftest handshake for the head record
//   dt_pc, dt_inst        : head commit record
//   instr_cnt, cycle_cnt  : retired instructions / cycles spent in RUN or DRAIN
//   halt, halt_code       : simulation end flag and cause (zero while running)
module commit_ctrl
  import npc_commit_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [63:0] pc,
  input  logic        is_break,
  input  logic [63:0] a0,
  output logic        stall,
  output logic        dt_valid,
  input  logic        dt_ready,
  output logic [63:0] dt_pc,
  output logic [31:0] dt_inst,
  output logic [63:0] instr_cnt,
  output logic [63:0] cycle_cnt,
  output logic        halt,
  output logic [1:0]  halt_code
);

  if (WDOG_LIMIT < 1) begin : g_bad_limit
    $error("commit_ctrl: WDOG_LIMIT must be at least 1");
  end

  state_t                state;
  state_t                state_nxt;
  halt_code_t            code_q;
  halt_code_t            code_nxt;
  logic                  a0_zero_q;
  logic                  accept;
  logic                  pop_fire;
  logic                  drained;
  logic                  wdog_expire;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_level;
  commit_rec_t           head;

  assign stall    = (state != RUN) || fifo_full;
  assign accept   = inst_valid && !stall;
  assign dt_valid = !fifo_empty;
  assign pop_fire = dt_valid && dt_ready;
  assign dt_pc    = head.pc;
  assign dt_inst  = head.inst;
  assign halt     = (state == HALT);
  assign halt_code = halt ? code_q : HC_NONE;

  // True when the FIFO is empty after this edge, so DRAIN leaves on the same
  // edge that pops the last record. No push can occur outside RUN.
  assign drained = fifo_empty || ((fifo_level == FIFO_CNT_W'(1)) && pop_fire);

  commit_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ('{pc: pc, inst: inst}),
    .pop       (dt_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (head)
  );

`ifdef COMMIT_CTRL_WDOG_EN
  logic [31:0] wdog_cnt;

  // Counts consecutive RUN cycles without a commit; expires on the edge that
  // would make the count reach WDOG_LIMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (state == RUN) begin
      wdog_cnt <= accept ? '0 : wdog_cnt + 32'd1;
    end
  end

  assign wdog_expire = (state == RUN) && !accept && (wdog_cnt == 32'(WDOG_LIMIT - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  // Next-state logic; the halt cause is decided at the transition into HALT.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (accept && is_break) begin
          state_nxt = DRAIN;
        end else if (wdog_expire) begin
          state_nxt = HALT;
          code_nxt  = HC_TIMEOUT;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nxt = HALT;
          code_nxt  = a0_zero_q ? HC_GOOD : HC_BAD;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      code_q    <= HC_NONE;
      a0_zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      if (accept && is_break) begin
        a0_zero_q <= (a0 == 64'd0);
      end
    end
  end

  // Both counters wrap at 2^64 by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (accept) begin
        instr_cnt <= instr_cnt + 64'd1;
      end
      if ((state == RUN) || (state == DRAIN)) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl
// Scoreboard bench for commit_ctrl (WDOG_LIMIT=8). Records expected to be
// accepted are queued when driven and compared when difftest pops them.
// Watchdog expectations follow COMMIT_CTRL_WDOG_EN.
module tb_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;
  logic        is_break = 1'b0;
  logic [63:0] a0 = '0;
  logic        dt_ready = 1'b0;
  logic        stall;
  logic        dt_valid;
  logic [63:0] dt_pc;
  logic [31:0] dt_inst;
  logic [63:0] instr_cnt;
  logic [63:0] cycle_cnt;
  logic        halt;
  logic [1:0]  halt_code;

  int          checks = 0;
  int          errors = 0;
  logic [95:0] sb [$];
  logic [95:0] sb_exp;

  always #5 clk = ~clk;

  commit_ctrl #(.WDOG_LIMIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .is_break   (is_break),
    .a0         (a0),
    .stall      (stall),
    .dt_valid   (dt_valid),
    .dt_ready   (dt_ready),
    .dt_pc      (dt_pc),
    .dt_inst    (dt_inst),
    .instr_cnt  (instr_cnt),
    .cycle_cnt  (cycle_cnt),
    .halt       (halt),
    .halt_code  (halt_code)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] p, input logic [31:0] i,
                               input logic brk, input logic [63:0] a, input logic exp_accept);
    inst_valid = valid;
    pc         = p;
    inst       = i;
    is_break   = brk;
    a0         = a;
    if (exp_accept) sb.push_back({p, i});
    tick();
  endtask

  task automatic idle(input int n);
    inst_valid = 1'b0;
    is_break   = 1'b0;
    repeat (n) tick();
  endtask

  // Compare every record difftest consumes against the scoreboard head.
  always @(negedge clk) begin
    if (dt_valid && dt_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_pop", 64'd1, 64'd0);
      end else begin
        sb_exp = sb.pop_front();
        checkOutput("sb_pc", dt_pc, sb_exp[95:32]);
        checkOutput("sb_inst", {32'd0, dt_inst}, {32'd0, sb_exp[31:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no finish, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    dt_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_stall", stall, 1);
    checkOutput("rst_dt_valid", dt_valid, 0);
    checkOutput("rst_dt_pc", dt_pc, 0);
    checkOutput("rst_dt_inst", dt_inst, 0);
    checkOutput("rst_halt", halt, 0);
    checkOutput("rst_halt_code", halt_code, 0);
    checkOutput("rst_instr_cnt", instr_cnt, 0);
    checkOutput("rst_cycle_cnt", cycle_cnt, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("run_stall", stall, 0);

    // Back-to-back commits with difftest always ready
    dt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b0, 64'd0, 1'b1);
      checkOutput("b2b_dt_valid", dt_valid, 1);
    end
    idle(1);
    checkOutput("b2b_drained", dt_valid, 0);
    checkOutput("b2b_instr_cnt", instr_cnt, 3);
    checkOutput("b2b_cycle_cnt", cycle_cnt, 4);

    // Backpressure fills the FIFO and the third commit is held off
    dt_ready = 1'b0;
    applyStimulus(1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0, 64'd0, 1'b1);
    checkOutput("fill1_stall", stall, 0);
    applyStimulus(1'b1, 64'h8000_0004, 32'h0020_0113, 1'b0, 64'd0, 1'b1);
    checkOutput("full_stall", stall, 1);
    applyStimulus(1'b1, 64'h8000_0008, 32'h0030_0193, 1'b0, 64'd0, 1'b0);
    checkOutput("full_stall_held", stall, 1);
    checkOutput("held_dt_pc", dt_pc, 64'h8000_0000);
    checkOutput("full_instr_cnt", instr_cnt, 5);
    dt_ready = 1'b1;
    idle(2);
    checkOutput("full_drained", dt_valid, 0);

    // ebreak with a0=0, difftest stalls two cycles in DRAIN
    dt_ready = 1'b0;
    applyStimulus(1'b1, 64'h8000_0010, 32'h0010_0073, 1'b1, 64'd0, 1'b1);
    checkOutput("drain_stall", stall, 1);
    checkOutput("drain_dt_valid", dt_valid, 1);
    checkOutput("drain_halt", halt, 0);
    idle(1);
    checkOutput("drain_hold_halt", halt, 0);
    checkOutput("drain_hold_pc", dt_pc, 64'h8000_0010);
    dt_ready = 1'b1;
    idle(1);
    checkOutput("good_halt", halt, 1);
    checkOutput("good_code", halt_code, 2'b01);
    checkOutput("good_dt_valid", dt_valid, 0);
    checkOutput("good_instr_cnt", instr_cnt, 6);

    // ebreak with a0=1, later commits ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst2_instr_cnt", instr_cnt, 0);
    dt_ready = 1'b1;
    applyStimulus(1'b1, 64'h8000_0020, 32'h0010_0073, 1'b1, 64'd1, 1'b1);
    idle(1);
    checkOutput("bad_halt", halt, 1);
    checkOutput("bad_code", halt_code, 2'b10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'h8000_0024 + 64'(4 * i), 32'h0000_0013, 1'b0, 64'd0, 1'b0);
    end
    checkOutput("bad_instr_frozen", instr_cnt, 1);
    checkOutput("bad_halt_held", halt, 1);
    checkOutput("bad_code_held", halt_code, 2'b10);
    checkOutput("bad_dt_valid", dt_valid, 0);

    // Reset during DRAIN with two pending records
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dt_ready = 1'b0;
    applyStimulus(1'b1, 64'h8000_0100, 32'h0000_0013, 1'b0, 64'd0, 1'b1);
    applyStimulus(1'b1, 64'h8000_0104, 32'h0010_0073, 1'b1, 64'd0, 1'b1);
    inst_valid = 1'b0;
    is_break   = 1'b0;
    checkOutput("drain2_stall", stall, 1);
    checkOutput("drain2_dt_valid", dt_valid, 1);
    checkOutput("drain2_halt", halt, 0);
    checkOutput("drain2_instr_cnt", instr_cnt, 2);
    rst_n = 1'b0;
    sb.delete();
    tick();
    checkOutput("rst_drain_dt_valid", dt_valid, 0);
    checkOutput("rst_drain_instr_cnt", instr_cnt, 0);
    checkOutput("rst_drain_cycle_cnt", cycle_cnt, 0);
    checkOutput("rst_drain_idle_stall", stall, 1);
    checkOutput("rst_drain_halt", halt, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_drain_run", stall, 0);

    // Watchdog: eight RUN cycles without a commit
    idle(7);
    checkOutput("wdog_pre_halt", halt, 0);
    idle(1);
`ifdef COMMIT_CTRL_WDOG_EN
    checkOutput("wdog_halt", halt, 1);
    checkOutput("wdog_code", halt_code, 2'b11);
`else
    checkOutput("nowdog_halt", halt, 0);
    checkOutput("nowdog_code", halt_code, 2'b00);
    idle(30);
    checkOutput("nowdog_halt_late", halt, 0);
    checkOutput("nowdog_stall_late", stall, 0);
`endif

    checkOutput("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
